// File: rtl/cpu_regfile_pkg.sv
// rtl/cpu_regfile_pkg.sv - shared constants and types for the parametrised register bank
// Contents: default WIDTH/DEPTH, address/data word typedefs for the default build,
// and ZERO_ADDR (the index of the optional hardwired zero register).
package cpu_regfile_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_AW    = $clog2(DEF_DEPTH);
    localparam int ZERO_ADDR = 0;

    typedef logic [DEF_AW-1:0]    reg_addr_t;
    typedef logic [DEF_WIDTH-1:0] reg_word_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy scoreboard with write-clear bypass
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   set_en, set_addr      reservation from issue (marks register pending)
//   clr_en, clr_addr      writeback (clears pending), already qualified for the zero register
//   rd_addr1, rd_addr2    source operand addresses
//   busy1, busy2, stall   operand pending flags and their OR
//   busy_vec              raw scoreboard bits
module regfile_scoreboard
    import cpu_regfile_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic             busy1,
    output logic             busy2,
    output logic             stall,
    output logic [DEPTH-1:0] busy_vec
);
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Set is applied after clear so a same-cycle issue to the register being
    // written back leaves the new operation pending.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
        if (ZERO_REG != 0) busy_d[ZERO_ADDR] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A writeback landing this cycle releases the operand immediately; a
    // reservation made this cycle only shows up from the next cycle.
    always_comb begin
        busy1 = busy_q[rd_addr1] && !(clr_en && (clr_addr == rd_addr1));
        busy2 = busy_q[rd_addr2] && !(clr_en && (clr_addr == rd_addr2));
        if (reset) begin
            busy1 = 1'b0;
            busy2 = 1'b0;
        end
    end

    assign stall    = busy1 | busy2;
    assign busy_vec = reset ? '0 : busy_q;
endmodule

// File: rtl/registry_bank_param.sv
// rtl/registry_bank_param.sv - parametrised register bank, 1 write / 2 bypassed reads, busy scoreboard
// Ports:
//   clk, reset                   rising-edge clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data      writeback port
//   rd_addr1/2 -> rd_data1/2     combinational read ports with write-through bypass
//   rsv_en, rsv_addr             issue-stage destination reservation
//   busy1, busy2, stall          operand pending flags
//   busy_vec                     raw scoreboard bits
module registry_bank_param
    import cpu_regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    output logic             busy1,
    output logic             busy2,
    output logic             stall,
    output logic [DEPTH-1:0] busy_vec
);
    localparam logic [AW-1:0] ZADDR = AW'(ZERO_ADDR);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic             zero1;
    logic             zero2;

    // Writes to the hardwired zero register are dropped entirely, so they
    // neither update storage nor feed the read bypass.
    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == ZADDR));
    assign zero1 = (ZERO_REG != 0) && (rd_addr1 == ZADDR);
    assign zero2 = (ZERO_REG != 0) && (rd_addr2 == ZADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reset forces zero even when a bypassed write is presented on the bus.
    always_comb begin
        rd_data1 = mem[rd_addr1];
        if (wr_ok && (wr_addr == rd_addr1)) rd_data1 = wr_data;
        if (zero1 || reset) rd_data1 = '0;
    end

    always_comb begin
        rd_data2 = mem[rd_addr2];
        if (wr_ok && (wr_addr == rd_addr2)) rd_data2 = wr_data;
        if (zero2 || reset) rd_data2 = '0;
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (rsv_en),
        .set_addr (rsv_addr),
        .clr_en   (wr_ok),
        .clr_addr (wr_addr),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .busy1    (busy1),
        .busy2    (busy2),
        .stall    (stall),
        .busy_vec (busy_vec)
    );
endmodule

// File: tb/tb_registry_bank_param.sv
// tb/tb_registry_bank_param.sv - self-checking bench for registry_bank_param
module tb_registry_bank_param;
    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en, rsv_en;
    logic [3:0]  wr_addr, rd_addr1, rd_addr2, rsv_addr;
    logic [31:0] wr_data, rd_data1, rd_data2;
    logic        busy1, busy2, stall;
    logic [15:0] busy_vec;

    logic        w_wr_en, w_rsv_en;
    logic [4:0]  w_wr_addr, w_rd_addr1, w_rd_addr2, w_rsv_addr;
    logic [63:0] w_wr_data, w_rd_data1, w_rd_data2;
    logic        w_busy1, w_busy2, w_stall;
    logic [31:0] w_busy_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    registry_bank_param dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(busy1), .busy2(busy2),
        .stall(stall), .busy_vec(busy_vec)
    );

    registry_bank_param #(.WIDTH(64), .DEPTH(32), .ZERO_REG(0)) dut_w (
        .clk(clk), .reset(reset), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .rd_addr1(w_rd_addr1), .rd_addr2(w_rd_addr2), .rd_data1(w_rd_data1), .rd_data2(w_rd_data2),
        .rsv_en(w_rsv_en), .rsv_addr(w_rsv_addr), .busy1(w_busy1), .busy2(w_busy2),
        .stall(w_stall), .busy_vec(w_busy_vec)
    );

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0; rsv_en = 0; rsv_addr = 0;
        rd_addr1 = 0; rd_addr2 = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        w_wr_en = 0; w_wr_addr = 0; w_wr_data = 0; w_rsv_en = 0; w_rsv_addr = 0;
        w_rd_addr1 = 0; w_rd_addr2 = 0;
        repeat (2) @(negedge clk);
        rd_addr1 = 5; rd_addr2 = 9; #1;
        checks++;
        if ({rd_data1, rd_data2, busy1, busy2, stall, busy_vec} !== 83'd0) begin
            errors++; $display("FAIL reset_outputs got rd1=%h rd2=%h busy_vec=%h want all zero", rd_data1, rd_data2, busy_vec);
        end
        reset = 0;
        @(posedge clk);
    endtask

    task automatic test_zero_reg();
        @(negedge clk); idle(); wr_en = 1; wr_addr = 5; wr_data = 32'hAAAAAAAA;
        @(negedge clk); wr_addr = 0; wr_data = 32'hBBBBBBBB; rd_addr1 = 0; #1;
        checks++;
        if (rd_data1 !== 32'h0) begin
            errors++; $display("FAIL zero_bypass got %h want 00000000", rd_data1);
        end
        @(negedge clk); idle(); rd_addr1 = 0; rd_addr2 = 5; #1;
        checks++;
        if (rd_data1 !== 32'h0) begin
            errors++; $display("FAIL zero_read got %h want 00000000", rd_data1);
        end
        checks++;
        if (rd_data2 !== 32'hAAAAAAAA) begin
            errors++; $display("FAIL reg5_read got %h want AAAAAAAA", rd_data2);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk); idle(); wr_en = 1; wr_addr = 3; wr_data = 32'hCCCCCCCC;
        rd_addr1 = 3; rd_addr2 = 4; #1;
        checks++;
        if (rd_data1 !== 32'hCCCCCCCC) begin
            errors++; $display("FAIL bypass_rd1 got %h want CCCCCCCC", rd_data1);
        end
        checks++;
        if (rd_data2 !== 32'h0) begin
            errors++; $display("FAIL unwritten_rd2 got %h want 00000000", rd_data2);
        end
        @(negedge clk); wr_addr = 4; wr_data = 32'hDDDDDDDD; #1;
        checks++;
        if (rd_data1 !== 32'hCCCCCCCC || rd_data2 !== 32'hDDDDDDDD) begin
            errors++; $display("FAIL bypass_next got %h/%h want CCCCCCCC/DDDDDDDD", rd_data1, rd_data2);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk); idle(); rsv_en = 1; rsv_addr = 7; rd_addr1 = 7; rd_addr2 = 4; #1;
        checks++;
        if (busy1 !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL rsv_same_cycle got busy1=%b stall=%b want 0 0", busy1, stall);
        end
        @(negedge clk); rsv_en = 0; #1;
        checks++;
        if (busy1 !== 1'b1 || stall !== 1'b1 || busy_vec !== 16'h0080) begin
            errors++; $display("FAIL rsv_pending got busy1=%b stall=%b vec=%h want 1 1 0080", busy1, stall, busy_vec);
        end
        @(negedge clk); wr_en = 1; wr_addr = 7; wr_data = 32'h12345678; #1;
        checks++;
        if (busy1 !== 1'b0 || stall !== 1'b0 || rd_data1 !== 32'h12345678) begin
            errors++; $display("FAIL wb_clear_bypass got busy1=%b stall=%b rd1=%h want 0 0 12345678", busy1, stall, rd_data1);
        end
        @(negedge clk); idle(); rd_addr1 = 7; #1;
        checks++;
        if (busy_vec !== 16'h0000 || rd_data1 !== 32'h12345678) begin
            errors++; $display("FAIL wb_cleared got vec=%h rd1=%h want 0000 12345678", busy_vec, rd_data1);
        end
    endtask

    task automatic test_set_beats_clear();
        @(negedge clk); idle(); rsv_en = 1; rsv_addr = 9; wr_en = 1; wr_addr = 9; wr_data = 32'h99990001;
        @(negedge clk); idle(); rd_addr1 = 9; #1;
        checks++;
        if (rd_data1 !== 32'h99990001 || busy_vec !== 16'h0200 || busy1 !== 1'b1) begin
            errors++; $display("FAIL set_beats_clear got rd1=%h vec=%h busy1=%b want 99990001 0200 1", rd_data1, busy_vec, busy1);
        end
        @(negedge clk); rsv_en = 1; rsv_addr = 0;
        @(negedge clk); idle(); rd_addr1 = 0; #1;
        checks++;
        if (busy_vec !== 16'h0200 || busy1 !== 1'b0) begin
            errors++; $display("FAIL zero_never_busy got vec=%h busy1=%b want 0200 0", busy_vec, busy1);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); idle(); rsv_en = 1; rsv_addr = 2;
        @(negedge clk); idle(); wr_en = 1; wr_addr = 6; wr_data = 32'h0000FFFF;
        @(negedge clk); wr_data = 32'h12121212; rd_addr1 = 6; rd_addr2 = 2; #1;
        checks++;
        if (rd_data1 !== 32'h12121212 || busy2 !== 1'b1) begin
            errors++; $display("FAIL pre_reset got rd1=%h busy2=%b want 12121212 1", rd_data1, busy2);
        end
        #1 reset = 1; #1;
        checks++;
        if ({rd_data1, rd_data2, busy1, busy2, stall, busy_vec} !== 83'd0) begin
            errors++; $display("FAIL async_reset got rd1=%h rd2=%h b2=%b vec=%h want all zero", rd_data1, rd_data2, busy2, busy_vec);
        end
        @(negedge clk); idle(); rd_addr1 = 6;
        @(negedge clk); reset = 0; #1;
        checks++;
        if (rd_data1 !== 32'h0 || busy_vec !== 16'h0) begin
            errors++; $display("FAIL after_reset got rd1=%h vec=%h want 00000000 0000", rd_data1, busy_vec);
        end
    endtask

    task automatic test_random();
        logic [31:0] m_mem [16];
        logic [15:0] m_busy;
        logic [31:0] e1, e2;
        logic        eb1, eb2;
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        m_busy = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            wr_en = 1'($urandom); rsv_en = 1'($urandom_range(0, 2) == 0);
            wr_data = $urandom;
            wr_addr  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            rsv_addr = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            rd_addr1 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            rd_addr2 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            #1;
            e1 = (rd_addr1 == 0) ? 32'h0 : (wr_en && wr_addr == rd_addr1) ? wr_data : m_mem[rd_addr1];
            e2 = (rd_addr2 == 0) ? 32'h0 : (wr_en && wr_addr == rd_addr2) ? wr_data : m_mem[rd_addr2];
            eb1 = m_busy[rd_addr1] && !(wr_en && wr_addr == rd_addr1);
            eb2 = m_busy[rd_addr2] && !(wr_en && wr_addr == rd_addr2);
            checks++;
            if (rd_data1 !== e1 || rd_data2 !== e2) begin
                errors++; $display("FAIL rnd_read cycle %0d got %h/%h want %h/%h", c, rd_data1, rd_data2, e1, e2);
            end
            checks++;
            if (busy1 !== eb1 || busy2 !== eb2 || stall !== (eb1 | eb2) || busy_vec !== m_busy) begin
                errors++; $display("FAIL rnd_busy cycle %0d got %b%b%b vec=%h want %b%b%b vec=%h",
                                   c, busy1, busy2, stall, busy_vec, eb1, eb2, eb1 | eb2, m_busy);
            end
            @(posedge clk);
            if (wr_en) begin
                if (wr_addr != 0) m_mem[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (rsv_en) m_busy[rsv_addr] = 1'b1;
            m_busy[0] = 1'b0;
        end
        @(negedge clk); idle();
    endtask

    task automatic test_wide_nozero();
        @(negedge clk); w_wr_en = 1; w_wr_addr = 0; w_wr_data = 64'h0123456789ABCDEF;
        @(negedge clk); w_wr_addr = 31; w_wr_data = 64'hFEDCBA9876543210;
        @(negedge clk); w_wr_en = 0; w_rsv_en = 1; w_rsv_addr = 0; w_rd_addr1 = 0; w_rd_addr2 = 31; #1;
        checks++;
        if (w_rd_data1 !== 64'h0123456789ABCDEF || w_rd_data2 !== 64'hFEDCBA9876543210) begin
            errors++; $display("FAIL wide_read got %h/%h want 0123456789abcdef/fedcba9876543210", w_rd_data1, w_rd_data2);
        end
        checks++;
        if (w_busy1 !== 1'b0) begin
            errors++; $display("FAIL wide_rsv_same_cycle got %b want 0", w_busy1);
        end
        @(negedge clk); w_rsv_en = 0; #1;
        checks++;
        if (w_busy_vec !== 32'h00000001 || w_busy1 !== 1'b1 || w_stall !== 1'b1) begin
            errors++; $display("FAIL wide_reg0_busy got vec=%h busy1=%b stall=%b want 00000001 1 1", w_busy_vec, w_busy1, w_stall);
        end
    endtask

    initial begin
        test_reset();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_set_beats_clear();
        test_async_reset();
        test_random();
        test_wide_nozero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/registry_bank_param.md
Name: registry_bank_param

Overview:
Parametrised, clocked successor to the 16x32 register bank. It has one write port and two combinational read ports with write-through bypass, plus an optional hardwired zero register. A per-register busy scoreboard lets the issue stage reserve a destination and stall on pending operands until writeback clears it. Sits between decode/issue and writeback in the CPU datapath.

Parameters:
WIDTH, 32, data width of each register in bits
DEPTH, 16, number of registers (power of two, >= 2)
AW, $clog2(DEPTH), address width (derived; do not override)
ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never busy; 0 = register 0 is ordinary

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
wr_en  in  1  writeback strobe
wr_addr  in  AW  writeback destination (d)
wr_data  in  WIDTH  writeback data (ldr)
rd_addr1  in  AW  source operand 1 (s1)
rd_addr2  in  AW  source operand 2 (s2)
rd_data1  out  WIDTH  operand 1 data
rd_data2  out  WIDTH  operand 2 data
rsv_en  in  1  issue strobe: mark rsv_addr pending
rsv_addr  in  AW  destination being reserved
busy1  out  1  operand 1 pending
busy2  out  1  operand 2 pending
stall  out  1  busy1 | busy2
busy_vec  out  DEPTH  raw scoreboard bits, for debug/bench

Behaviour:
- Reset (async, active-high): every register clears to 0 and every busy bit clears to 0 immediately, independent of clk. While reset is high, rd_data1/2 = 0, busy1/2 = 0, stall = 0 and busy_vec = 0. Writes and reservations are ignored while reset is high. Deassertion takes effect at the next rising edge.
- Write: on a rising edge with wr_en=1, mem[wr_addr] <= wr_data. If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read: combinational, zero latency. rd_dataN = mem[rd_addrN], with these overrides in priority order:
  - ZERO_REG=1 and rd_addrN=0 -> 0.
  - wr_en=1 and wr_addr=rd_addrN (and the write is not dropped) -> wr_data. This bypass means a same-cycle writeback is visible to the reader.
- Both read ports may target the same address, including the write address. Each port resolves independently.
- Scoreboard next-state, per register i at each rising edge:
  - set when rsv_en=1 and rsv_addr=i;
  - else clear when wr_en=1 and wr_addr=i;
  - else hold.
  - Set beats clear when both hit the same register in the same cycle, so the newly issued op stays pending.
  - Reserving an already-busy register is legal: it stays busy and no error is raised.
  - Writing a non-busy register is legal: the data updates and busy stays 0.
  - With ZERO_REG=1, busy bit 0 is tied to 0.
- busyN is combinational from the current busy bit, with write-clear bypass: busyN = busy[rd_addrN] & ~(wr_en & wr_addr=rd_addrN). A same-cycle reservation does NOT assert busyN; it takes effect from the next cycle.
- stall = busy1 | busy2. There is no read-enable qualification; the issue stage masks unused ports.
- All address inputs are full range (AW bits, DEPTH entries), so no out-of-range case exists.

Decomposition:
- Shared package cpu_regfile_pkg holds:
  - default WIDTH/DEPTH constants;
  - a typedef for register address and data words;
  - a localparam ZERO_ADDR = 0.
- One natural sub-module: regfile_scoreboard. It owns the busy bits, set/clear priority, the write-clear bypass, busy1/busy2/stall and busy_vec.
- The top level owns the storage array, the write logic and the read bypass muxes.

Test Plan:
- Reset, then write d=5 with AAAAAAAA, then d=0 with BBBBBBBB (ZERO_REG=1); read s1=0, s2=5 -> rd_data1=00000000, rd_data2=AAAAAAAA.
- wr_en=1, d=3, CCCCCCCC with s1=3, s2=4 in the same cycle -> rd_data1=CCCCCCCC in that cycle (bypass). The next cycle, d=4, DDDDDDDD -> rd_data1=CCCCCCCC, rd_data2=DDDDDDDD.
- rsv_en on reg 7, then read s1=7 -> busy1=0 in the reserving cycle, then busy1=1 and stall=1. A writeback to 7 with 12345678 -> busy1=0 and rd_data1=12345678 in that same cycle; busy_vec[7]=0 afterwards.
- Same-cycle rsv_en and wr_en, both on reg 9 -> after the edge, mem[9] holds the write data and busy_vec[9]=1.
- Reserve reg 2, write reg 6 with 0000FFFF, then assert reset asynchronously mid-cycle -> all outputs go to 0 before the next edge; after reset, reading reg 6 returns 00000000 and busy_vec=0.
- ZERO_REG=0 build, DEPTH=32, WIDTH=64: write reg 0 and reg 31, then reserve reg 0 -> both read back their values, and busy_vec[0]=1.
